polynomial_eval: RTL and testbench

Parametrised sequential evaluator of an unsigned polynomial p(x) = sum coef[i]*x^i of configurable degree, using Horner's method with a shift-add multiplier.
Generalises the fixed quadratic evaluator to any degree and any operand width, and adds a sticky overflow flag.
Sits as a compute slave behind the same inicio/pronto handshake used by the existing arithmetic blocks.

---
 rtl/polynomial_eval_pkg.sv | 18 +
 rtl/polynomial_eval_shift_add_mul.sv | 76 +++++++
 rtl/polynomial_eval.sv | 165 ++++++++++++++++
 tb/tb_polynomial_eval.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/polynomial_eval_pkg.sv
// Shared definitions for the Horner polynomial evaluator: FSM state encoding
// and the coefficient slice helper.
package polynomial_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MULT = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // LSB position of coefficient i inside the flat coefficient vector.
  function automatic int unsigned coef_lsb(input int unsigned i, input int unsigned cw);
    return i * cw;
  endfunction

endpackage

// File: rtl/polynomial_eval_shift_add_mul.sv
// Sequential shift-add multiplier: a start pulse loads the operands, then one
// partial product is accumulated per cycle for BW cycles.
module shift_add_mul
  import polynomial_eval_pkg::*;
#(
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             done,
  output logic [AW+BW-1:0] prod
);

  localparam int PW   = AW + BW;
  localparam int CNTW = $clog2(BW + 1);

  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [BW-1:0]   xsh_q, xsh_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // Operand load on start, otherwise one shift-add step per busy cycle.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    xsh_d   = xsh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      prod_d  = {PW{1'b0}};
      mcand_d = PW'(a);
      xsh_d   = b;
      cnt_d   = CNTW'(BW);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (xsh_q[0]) begin
        prod_d = prod_q + mcand_q;
      end else begin
        prod_d = prod_q;
      end
      mcand_d = mcand_q << 1'b1;
      xsh_d   = xsh_q >> 1'b1;
      cnt_d   = cnt_q - CNTW'(1);
      busy_d  = (cnt_q != CNTW'(1));
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= {PW{1'b0}};
      mcand_q <= {PW{1'b0}};
      xsh_q   <= {BW{1'b0}};
      cnt_q   <= {CNTW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      xsh_q   <= xsh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // High during the final step: prod holds the full product after this edge.
  assign done = busy_q && (cnt_q == CNTW'(1));
  assign prod = prod_q;

endmodule

// File: rtl/polynomial_eval.sv
// Horner evaluator of an unsigned polynomial with sticky overflow flag,
// behind the inicio/pronto handshake.
module polynomial_eval
  import polynomial_eval_pkg::*;
#(
  parameter int DEGREE = 2,
  parameter int XW     = 8,
  parameter int CW     = 16,
  parameter int RW     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [XW-1:0]            x,
  input  logic [(DEGREE+1)*CW-1:0] coefs,
  input  logic                     inicio,
  output logic                     pronto,
  output logic [RW-1:0]            resultado,
  output logic                     erro,
  output logic                     ocupado
);

  localparam int PW   = RW + XW;
  localparam int FW   = (DEGREE + 1) * CW;
  localparam int IDXW = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'((DEGREE > 0) ? DEGREE - 1 : 0);

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [FW-1:0]   coefs_q, coefs_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            erro_q, erro_d;
  logic [RW-1:0]   res_q, res_d;
  logic            pronto_q, pronto_d;
  logic            ocupado_q, ocupado_d;

  logic            mul_start_s;
  logic            mul_done_s;
  logic [PW-1:0]   mul_prod_s;
  logic [CW-1:0]   coef_top_s;
  logic [CW-1:0]   coef_idx_s;
  logic [PW:0]     sum_s;
  logic            ovf_s;

  assign coef_top_s = coefs_q[coef_lsb(DEGREE, CW) +: CW];
  assign coef_idx_s = coefs_q[coef_lsb(int'(idx_q), CW) +: CW];
  assign sum_s      = (PW + 1)'(mul_prod_s) + (PW + 1)'(coef_idx_s);
  assign ovf_s      = |sum_s[PW:RW];

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = inicio ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = (DEGREE == 0) ? ST_DONE : ST_MULT;
      ST_MULT: state_d = mul_done_s ? ST_ADD : ST_MULT;
      ST_ADD:  state_d = (idx_q == {IDXW{1'b0}}) ? ST_DONE : ST_MULT;
      ST_DONE: state_d = inicio ? ST_DONE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, registered from the next state.
  always_comb begin
    pronto_d  = (state_d == ST_DONE);
    ocupado_d = (state_d == ST_LOAD) || (state_d == ST_MULT) || (state_d == ST_ADD);
  end

  // Datapath: operand latch, Horner accumulate and multiplier launch.
  always_comb begin
    x_d         = x_q;
    coefs_d     = coefs_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    erro_d      = erro_q;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inicio) begin
          x_d     = x;
          coefs_d = coefs;
        end else begin
          x_d     = x_q;
          coefs_d = coefs_q;
        end
      end
      ST_LOAD: begin
        acc_d       = RW'(coef_top_s);
        idx_d       = IDX_TOP;
        erro_d      = 1'b0;
        mul_start_s = (DEGREE != 0);
      end
      ST_ADD: begin
        acc_d  = sum_s[RW-1:0];
        erro_d = erro_q | ovf_s;
        if (idx_q != {IDXW{1'b0}}) begin
          idx_d       = idx_q - IDXW'(1);
          mul_start_s = 1'b1;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        mul_start_s = 1'b0;
      end
    endcase
    // The result register only changes on entry to DONE so IDLE keeps it.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_d = acc_d;
    end else begin
      res_d = res_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q       <= {XW{1'b0}};
      coefs_q   <= {FW{1'b0}};
      acc_q     <= {RW{1'b0}};
      idx_q     <= {IDXW{1'b0}};
      erro_q    <= 1'b0;
      res_q     <= {RW{1'b0}};
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      coefs_q   <= coefs_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      erro_q    <= erro_d;
      res_q     <= res_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  shift_add_mul #(
    .AW(RW),
    .BW(XW)
  ) u_mul (
    .clk  (clock),
    .rst_n(reset),
    .start(mul_start_s),
    .a    (acc_d),
    .b    (x_q),
    .done (mul_done_s),
    .prod (mul_prod_s)
  );

  assign pronto    = pronto_q;
  assign resultado = res_q;
  assign erro      = erro_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_polynomial_eval.sv
// Directed, table-driven bench for polynomial_eval (DEGREE=2 and DEGREE=0
// builds), with hand-written reset and degree-0 sequences.
module tb_polynomial_eval;

  localparam int DEGREE = 2;
  localparam int XW     = 8;
  localparam int CW     = 16;
  localparam int RW     = 16;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [XW-1:0]            x;
  logic [(DEGREE+1)*CW-1:0] coefs;
  logic                     inicio;
  logic                     pronto;
  logic [RW-1:0]            resultado;
  logic                     erro;
  logic                     ocupado;

  logic [XW-1:0] x0;
  logic [CW-1:0] coefs0;
  logic          inicio0;
  logic          pronto0;
  logic [RW-1:0] resultado0;
  logic          erro0;
  logic          ocupado0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  polynomial_eval #(.DEGREE(DEGREE), .XW(XW), .CW(CW), .RW(RW)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .x        (x),
    .coefs    (coefs),
    .inicio   (inicio),
    .pronto   (pronto),
    .resultado(resultado),
    .erro     (erro),
    .ocupado  (ocupado)
  );

  polynomial_eval #(.DEGREE(0), .XW(XW), .CW(CW), .RW(RW)) u_dut0 (
    .clock    (clock),
    .reset    (reset),
    .x        (x0),
    .coefs    (coefs0),
    .inicio   (inicio0),
    .pronto   (pronto0),
    .resultado(resultado0),
    .erro     (erro0),
    .ocupado  (ocupado0)
  );

  typedef struct {
    logic [7:0]  vx;
    logic [15:0] c2;
    logic [15:0] c1;
    logic [15:0] c0;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start with inicio held high, scramble inputs mid-run, check result,
  // hold inicio to confirm no relaunch, then drop it and check IDLE.
  task automatic run_vec(input vec_t v);
    int   lat;
    logic [15:0] r;
    @(negedge clock);
    x      = v.vx;
    coefs  = {v.c2, v.c1, v.c0};
    inicio = 1'b1;
    lat    = -1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clock);
      #1;
      if (e == 0) check("ocupado_load", 32'(ocupado), 32'd1);
      if (e == 3) begin
        x     = ~v.vx;
        coefs = ~{v.c2, v.c1, v.c0};
      end
      if (pronto) begin
        lat = e;
        break;
      end
    end
    check("latency", 32'(lat), 32'd19);
    check("resultado", 32'(resultado), 32'(v.res));
    check("erro", 32'(erro), 32'(v.err));
    r = resultado;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check("hold_pronto", 32'(pronto), 32'd1);
      check("hold_ocupado", 32'(ocupado), 32'd0);
      check("hold_res", 32'(resultado), 32'(r));
    end
    @(negedge clock);
    inicio = 1'b0;
    @(posedge clock);
    #1;
    check("idle_pronto", 32'(pronto), 32'd0);
    check("idle_res", 32'(resultado), 32'(v.res));
    check("idle_erro", 32'(erro), 32'(v.err));
    check("idle_ocupado", 32'(ocupado), 32'd0);
  endtask

  initial begin
    int lat0;
    vecs[0] = '{vx: 8'd1,   c2: 16'd3,     c1: 16'd3,   c0: 16'd0,   res: 16'd6,     err: 1'b0};
    vecs[1] = '{vx: 8'd5,   c2: 16'd2,     c1: 16'd3,   c0: 16'd7,   res: 16'd72,    err: 1'b0};
    vecs[2] = '{vx: 8'd255, c2: 16'd2,     c1: 16'd0,   c0: 16'd0,   res: 16'd64514, err: 1'b1};
    vecs[3] = '{vx: 8'd0,   c2: 16'd9,     c1: 16'd8,   c0: 16'd4,   res: 16'd4,     err: 1'b0};
    vecs[4] = '{vx: 8'd3,   c2: 16'd100,   c1: 16'd200, c0: 16'd300, res: 16'd1800,  err: 1'b0};
    vecs[5] = '{vx: 8'd1,   c2: 16'hFFFF,  c1: 16'd1,   c0: 16'd0,   res: 16'd0,     err: 1'b1};
    vecs[6] = '{vx: 8'd2,   c2: 16'h8000,  c1: 16'd0,   c0: 16'd5,   res: 16'd5,     err: 1'b1};

    reset   = 1'b0;
    x       = '0;
    coefs   = '0;
    inicio  = 1'b1;
    x0      = '0;
    coefs0  = '0;
    inicio0 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_res", 32'(resultado), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst0_pronto", 32'(pronto0), 32'd0);
    @(negedge clock);
    inicio = 1'b0;
    reset  = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Reset during the second Horner step's multiply.
    @(negedge clock);
    x      = 8'd2;
    coefs  = {16'h8000, 16'd0, 16'd5};
    inicio = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(posedge clock);
      #1;
      if (e == 12) check("sticky_pre_reset", 32'(erro), 32'd1);
    end
    check("res_pre_reset", 32'(resultado), 32'd5);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_pronto", 32'(pronto), 32'd0);
    check("midrst_res", 32'(resultado), 32'd0);
    check("midrst_erro", 32'(erro), 32'd0);
    check("midrst_ocupado", 32'(ocupado), 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    inicio = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_idle", 32'(ocupado), 32'd0);
    run_vec(vecs[1]);

    // Degree-0 build: single coefficient, one-edge latency.
    @(negedge clock);
    x0      = 8'h55;
    coefs0  = 16'h1234;
    inicio0 = 1'b1;
    lat0    = -1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clock);
      #1;
      if (pronto0) begin
        lat0 = e;
        break;
      end
    end
    check("deg0_latency", 32'(lat0), 32'd1);
    check("deg0_res", 32'(resultado0), 32'h1234);
    check("deg0_erro", 32'(erro0), 32'd0);
    @(negedge clock);
    inicio0 = 1'b0;
    @(posedge clock);
    #1;
    check("deg0_idle_pronto", 32'(pronto0), 32'd0);
    check("deg0_idle_res", 32'(resultado0), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
